// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling engine: FSM states, mode
// encodings, reciprocal fraction width and a constant-safe clog2.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE,
    OUT
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  localparam int unsigned FRAC_W = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling channel: running max/sum accumulator plus the scale stage that
// turns the accumulator into a DATA_W result (truncate for max, scaled and
// rounded for average).
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              first,
  input  logic              scale,
  input  logic              mode,
  input  logic [DATA_W-1:0] x,
  input  logic [FRAC_W-1:0] recip,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned P_W = ACC_W + FRAC_W + 1;
  localparam logic signed [P_W-1:0] HALF   = P_W'(1) << (FRAC_W - 1);
  localparam logic signed [P_W-1:0] SAT_HI = P_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   rounded;
  logic signed [P_W-1:0]   shifted;
  logic        [DATA_W-1:0] scaled;

  always_comb begin
    x_ext = {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
    if (first) begin
      acc_next = x_ext;
    end else if (mode == MODE_AVG) begin
      acc_next = acc + x_ext;
    end else begin
      acc_next = (x_ext > acc) ? x_ext : acc;
    end
  end

  // Reciprocal is unsigned Q0.16, so it is zero-extended before the signed multiply.
  always_comb begin
    prod    = P_W'(acc) * P_W'($signed({1'b0, recip}));
    rounded = prod + HALF;
    shifted = rounded >>> FRAC_W;
    if (shifted > SAT_HI) begin
      scaled = SAT_HI[DATA_W-1:0];
    end else if (shifted < SAT_LO) begin
      scaled = SAT_LO[DATA_W-1:0];
    end else begin
      scaled = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (beat) acc <= acc_next;
      if (scale) result <= (mode == MODE_AVG) ? scaled : acc[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/pool_engine.sv
// Pooling engine: shared window/output FSM driving LANES parallel pool_lane
// channels; one reduced result per streamed window.
module pool_engine
  import pool_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned LANES  = 4,
  parameter  int unsigned K_MAX  = 3,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned WL_W   = clog2(K_MAX * K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_mode,
  input  logic [WL_W-1:0]         cfg_win_len,
  input  logic [CNT_W-1:0]        cfg_out_count,
  input  logic [FRAC_W-1:0]       cfg_recip,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data
);

  localparam int unsigned ACC_W = DATA_W + clog2(K_MAX * K_MAX);

  state_t            state;
  logic              mode_q;
  logic [WL_W-1:0]   win_len_q;
  logic [CNT_W-1:0]  out_count_q;
  logic [FRAC_W-1:0] recip_q;
  logic [WL_W-1:0]   elem_cnt;
  logic [CNT_W-1:0]  win_cnt;

  logic beat;
  logic first;
  logic last_beat;
  logic scale;
  logic last_window;

  always_comb begin
    beat        = (state == ACC) && in_valid && in_ready;
    first       = beat && (elem_cnt == '0);
    last_beat   = (elem_cnt + WL_W'(1)) == win_len_q;
    scale       = (state == SCALE);
    last_window = (win_cnt + CNT_W'(1)) == out_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_MAX;
      win_len_q   <= '0;
      out_count_q <= '0;
      recip_q     <= '0;
      elem_cnt    <= '0;
      win_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            mode_q      <= cfg_mode;
            win_len_q   <= (cfg_win_len == '0) ? WL_W'(1) : cfg_win_len;
            out_count_q <= cfg_out_count;
            recip_q     <= cfg_recip;
            elem_cnt    <= '0;
            win_cnt     <= '0;
            // An empty layer completes immediately without visiting ACC.
            if (cfg_out_count == '0) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            elem_cnt <= elem_cnt + WL_W'(1);
            if (last_beat) begin
              in_ready <= 1'b0;
              state    <= SCALE;
            end
          end
        end
        SCALE: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            elem_cnt  <= '0;
            win_cnt   <= win_cnt + CNT_W'(1);
            if (last_window) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              in_ready <= 1'b1;
              state    <= ACC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .beat   (beat),
      .first  (first),
      .scale  (scale),
      .mode   (mode_q),
      .x      (in_data[g*DATA_W +: DATA_W]),
      .recip  (recip_q),
      .result (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine: expected window results are pushed when
// beats are driven and popped when the engine presents each output.
module tb_pool_engine;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int K_MAX  = 3;
  localparam int CNT_W  = 16;
  localparam int WL_W   = $clog2(K_MAX * K_MAX + 1);
  localparam int W      = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic             cfg_mode;
  logic [WL_W-1:0]  cfg_win_len;
  logic [CNT_W-1:0] cfg_out_count;
  logic [15:0]      cfg_recip;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           beats[16][LANES];
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  pool_engine #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .K_MAX  (K_MAX),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_mode      (cfg_mode),
    .cfg_win_len   (cfg_win_len),
    .cfg_out_count (cfg_out_count),
    .cfg_recip     (cfg_recip),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang want completion");
    $fatal(1, "watchdog");
  end

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // Reference model: plain integer max / sum, then sum*recip rounded half-up and clamped.
  function automatic logic [W-1:0] expected(input bit mode, input longint recip, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      longint acc;
      longint r;
      acc = beats[0][l];
      for (int i = 1; i < n; i++) begin
        if (mode) acc = acc + beats[i][l];
        else if (beats[i][l] > acc) acc = beats[i][l];
      end
      if (!mode) begin
        r = acc;
      end else begin
        r = (acc * recip + 32768) >>> 16;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
      end
      v[l*DATA_W +: DATA_W] = r[DATA_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] pack_beat(input int i);
    logic [W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = DATA_W'(beats[i][l]);
    return d;
  endfunction

  task automatic start_layer(input bit mode, input int wl, input int oc, input int rc);
    @(negedge clk);
    cfg_mode      = mode;
    cfg_win_len   = WL_W'(wl);
    cfg_out_count = CNT_W'(oc);
    cfg_recip     = 16'(rc);
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start     = 1'b0;
    cfg_mode      = ~mode;
    cfg_win_len   = WL_W'($urandom);
    cfg_out_count = CNT_W'($urandom);
    cfg_recip     = 16'($urandom);
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout got in_ready=0 want 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_window(input int n);
    for (int i = 0; i < n; i++) send_beat(pack_beat(i));
  endtask

  task automatic wait_out(output logic [W-1:0] data, output logic ok, output logic dn);
    int t;
    t  = 0;
    dn = 1'b0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok   = out_valid;
    data = out_data;
    if (!ok) return;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    dn = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_start = 1'b0; cfg_mode = 1'b0; cfg_win_len = '0; cfg_out_count = '0; cfg_recip = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    rst = 1'b0;
  endtask

  task automatic test_max();
    logic [W-1:0] got, exp;
    logic ok, dn;
    int lane0[9] = '{3, -7, 12, 0, 5, 12, -1, 8, 2};
    for (int i = 0; i < 9; i++) begin
      beats[i][0] = lane0[i];
      for (int l = 1; l < LANES; l++) beats[i][l] = rnd16();
    end
    start_layer(1'b0, 9, 1, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL max_busy got %b want 1", busy); end
    sb.push_back(expected(1'b0, 0, 9));
    send_window(9);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL max_scale_cycle got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL max_latency got out_valid=%b want 1", out_valid); end
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL max_data got %h want %h", got, exp); end
    n_checks++; if (got[15:0] !== 16'd12) begin n_fail++; $display("FAIL max_lane0 got %0d want 12", $signed(got[15:0])); end
    n_checks++; if (dn !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL max_done got done=%b busy=%b want 1 0", dn, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL max_done_pulse got %b want 0", done); end
  endtask

  task automatic test_avg();
    logic [W-1:0] got, exp;
    logic ok, dn;
    start_layer(1'b1, 4, 2, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      beats[i][0] = i + 1;
      beats[i][1] = -(i + 1);
      beats[i][2] = 10 * (i + 1);
      beats[i][3] = rnd16();
    end
    sb.push_back(expected(1'b1, 16'h4000, 4));
    send_window(4);
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL avg_w0 got %h want %h", got, exp); end
    n_checks++;
    if (got[15:0] !== 16'd3 || got[31:16] !== 16'hFFFE || got[47:32] !== 16'd25) begin
      n_fail++; $display("FAIL avg_round got %h want lanes 3,-2,25", got[47:0]);
    end
    for (int i = 0; i < 4; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    sb.push_back(expected(1'b1, 16'h4000, 4));
    send_window(4);
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL avg_w1 got %h want %h", got, exp); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL avg_done got %b want 1", dn); end
  endtask

  task automatic test_avg_sat();
    logic [W-1:0] got, exp;
    logic ok, dn;
    start_layer(1'b1, 9, 2, 16'hFFFF);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 9; i++) for (int l = 0; l < LANES; l++) beats[i][l] = (w == 0) ? 32767 : -32768;
      sb.push_back(expected(1'b1, 16'hFFFF, 9));
      send_window(9);
      wait_out(got, ok, dn);
      exp = sb.pop_front();
      n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL sat_w%0d got %h want %h", w, got, exp); end
      n_checks++;
      if (got !== ((w == 0) ? {LANES{16'h7FFF}} : {LANES{16'h8000}})) begin
        n_fail++; $display("FAIL sat_clamp_w%0d got %h want full-scale", w, got);
      end
    end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL sat_done got %b want 1", dn); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got, exp;
    logic ok, dn, held;
    int t;
    start_layer(1'b0, 2, 2, 0);
    for (int i = 0; i < 2; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    sb.push_back(expected(1'b0, 0, 2));
    send_window(2);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    exp  = sb.pop_front();
    held = 1'b1;
    in_valid = 1'b1;
    in_data  = '1;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (!held) begin
      n_fail++; $display("FAIL bp_hold got valid=%b data=%h in_ready=%b want 1 %h 0", out_valid, out_data, in_ready, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_resume got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 2; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    sb.push_back(expected(1'b0, 0, 2));
    send_window(2);
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL bp_w1 got %h want %h", got, exp); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", dn); end
  endtask

  task automatic test_zero_count();
    logic quiet;
    start_layer(1'b0, 3, 0, 0);
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done got done=%b out_valid=%b want 1 0", done, out_valid);
    end
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL zero_quiet got activity after done want none"); end
  endtask

  task automatic test_win_len_zero();
    logic [W-1:0] got, exp;
    logic ok, dn;
    start_layer(1'b0, 0, 3, 0);
    for (int w = 0; w < 3; w++) begin
      for (int l = 0; l < LANES; l++) beats[0][l] = rnd16();
      sb.push_back(expected(1'b0, 0, 1));
      send_window(1);
      wait_out(got, ok, dn);
      exp = sb.pop_front();
      n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL wl0_w%0d got %h want %h", w, got, exp); end
    end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL wl0_done got %b want 1", dn); end
  endtask

  task automatic test_start_busy();
    logic [W-1:0] got, exp;
    logic ok, dn;
    start_layer(1'b0, 2, 1, 0);
    for (int i = 0; i < 2; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    sb.push_back(expected(1'b0, 0, 2));
    send_beat(pack_beat(0));
    cfg_mode = 1'b1; cfg_win_len = WL_W'(1); cfg_out_count = '0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_start got done=%b busy=%b want 0 1", done, busy);
    end
    send_beat(pack_beat(1));
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL busy_data got %h want %h", got, exp); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL busy_done got %b want 1", dn); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got, exp;
    logic ok, dn, quiet;
    start_layer(1'b1, 9, 1, 7282);
    for (int i = 0; i < 9; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    send_window(5);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got busy=%b done=%b in_ready=%b out_valid=%b data=%h want all 0",
                         busy, done, in_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL midrst_no_done got done/busy activity want none"); end
    start_layer(1'b1, 9, 1, 7282);
    for (int i = 0; i < 9; i++) for (int l = 0; l < LANES; l++) beats[i][l] = rnd16();
    sb.push_back(expected(1'b1, 7282, 9));
    send_window(9);
    wait_out(got, ok, dn);
    exp = sb.pop_front();
    n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL midrst_fresh got %h want %h", got, exp); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL midrst_done got %b want 1", dn); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_avg_sat();
    test_backpressure();
    test_zero_count();
    test_win_len_zero();
    test_start_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Parametrised successor to the v1 pooling core.
- Reduces streamed pooling windows to one result per window, across LANES parallel channels.
- Two modes: max and average. Window length, output count and the average reciprocal are programmed per layer by the CSB.
- Sits between the DMA read stream (window-ordered, one element per lane per beat) and the DMA write stream.

Parameters:
- DATA_W, 16, signed two's-complement element width.
- LANES, 4, channels processed in parallel per beat.
- K_MAX, 3, maximum kernel side; window length is at most K_MAX*K_MAX.
- CNT_W, 16, width of the output-window counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse that starts a layer; honoured only in IDLE.
- cfg_mode  in  1  0 = max, 1 = average.
- cfg_win_len  in  WL_W=clog2(K_MAX*K_MAX+1)  elements per window; 0 is treated as 1.
- cfg_out_count  in  CNT_W  number of windows in the layer.
- cfg_recip  in  16  unsigned Q0.16 reciprocal of the window length, used in average mode.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when the layer completes.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_W  one element per lane; lane i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  LANES*DATA_W  per-lane result.

Behaviour:
- Reset: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, state=IDLE, all counters 0.
- Reset mid-operation aborts the layer immediately. No done pulse is produced.
- Accumulator: ACC_W = DATA_W + clog2(K_MAX*K_MAX), signed, one per lane.

FSM states: IDLE, ACC, SCALE, OUT.
- IDLE:
  - cfg_start latches mode, win_len (0 becomes 1), out_count and recip.
  - busy=1 the next cycle.
  - If out_count==0: go to IDLE, pulse done one cycle after start, emit no outputs.
  - Otherwise go to ACC.
- ACC:
  - in_ready=1. Each accepted beat increments the element counter.
  - First beat of a window loads the accumulator with the sign-extended input.
  - Later beats take max(acc, x) in max mode or acc + x in average mode, per lane.
  - The beat that makes the counter equal win_len goes to SCALE; in_ready drops the following cycle.
  - in_valid low simply stalls; no timeout.
- SCALE (one cycle):
  - Max mode: result = acc truncated to DATA_W. This is exact, because acc always holds an input value.
  - Average mode: result = sat_DATA_W((acc * recip + 2^15) >>> 16). The product is signed ACC_W+17 bits; the shift is arithmetic, rounding half toward +inf.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the result into out_data; go to OUT.
- OUT:
  - out_valid=1. out_data is held stable until out_ready.
  - On the out_valid && out_ready cycle:
    - Clear the element counter and increment the window counter.
    - If the window counter now equals out_count: go to IDLE, busy=0, done=1 for that next cycle.
    - Otherwise go to ACC.
- Latency: accepting the last beat of a window to out_valid high is 2 cycles. Minimum window period is win_len+2 cycles.
- Ordering:
  - in_ready is never high in SCALE or OUT; input never overlaps output.
  - A new window's first beat may be accepted in the cycle after the output handshake.
- cfg_start while busy is ignored. Config inputs are only sampled at an accepted start.
- All lanes share the counters and state; lanes differ only in data.

Decomposition:
- Package pool_pkg holds:
  - the state enum (IDLE/ACC/SCALE/OUT) and the mode constants MODE_MAX=0, MODE_AVG=1;
  - the clog2 helper and the Q0.16 FRAC_W=16 constant.
- One sub-module, pool_lane:
  - per-lane accumulator, max/add select, and SCALE multiply/round/saturate;
  - instantiated LANES times with a generate loop under pool_engine's shared FSM.

Test Plan:
- Max, win_len=9, out_count=1, lane0 inputs 3,-7,12,0,5,12,-1,8,2 -> one output, lane0=12, done pulse 1 cycle after the handshake.
- Average, win_len=4, recip=0x4000, lane inputs 1,2,3,4 -> lane=3 (10/4=2.5 rounds to 3); inputs -1,-2,-3,-4 -> -2.
- Average saturation, win_len=9, recip=0xFFFF, all inputs 32767 -> 32767; all inputs -32768 -> -32768.
- Backpressure: out_ready low for 5 cycles in OUT -> out_valid/out_data stable, in_ready=0 throughout; stream resumes cleanly for the next window.
- out_count=0 -> done pulse, no out_valid. win_len=0 -> behaves as 1 (each input passes through). cfg_start while busy -> ignored.
- rst asserted mid-window (after 5 of 9 beats) -> all outputs 0 next edge; a fresh start then produces correct results from clean accumulators.
